// File: rtl/req_arb_fifo.sv
// -----------------------------------------------------------------------------
// req_arb_fifo
//
// Multi-channel request FIFO with round-robin read arbitration. Each of NUM_CH
// producers writes into a private DEPTH-entry FIFO. A single show-ahead read
// port presents the head word of the currently selected channel to the CPU.
// After each accepted pop, service moves to the next non-empty channel, so
// every channel gets one word per turn.
//
// Ports:
//   clk       in   single clock, all logic on the rising edge
//   rst       in   synchronous active-high reset
//   data_in   in   NUM_CH*WIDTH, channel c at [c*WIDTH +: WIDTH]
//   enq       in   NUM_CH per-channel write strobes
//   wrfull    out  NUM_CH per-channel full flags (registered)
//   data_out  out  WIDTH head word of the selected channel (valid when !rdempty)
//   src_ch    out  $clog2(NUM_CH) channel index of data_out
//   deq       in   pop the presented word
//   rdempty   out  selected channel holds no data
//   count     out  NUM_CH*($clog2(DEPTH)+1) per-channel occupancy (registered)
//   overflow  out  NUM_CH sticky flags: enq attempted while the channel was full
// -----------------------------------------------------------------------------
module req_arb_fifo #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 4,
    parameter int NUM_CH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_CH*WIDTH-1:0]               data_in,
    input  logic [NUM_CH-1:0]                     enq,
    output logic [NUM_CH-1:0]                     wrfull,
    output logic [WIDTH-1:0]                      data_out,
    output logic [$clog2(NUM_CH)-1:0]             src_ch,
    input  logic                                  deq,
    output logic                                  rdempty,
    output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]   count,
    output logic [NUM_CH-1:0]                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(NUM_CH);

    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    // Storage and per-channel state
    logic [WIDTH-1:0] mem_q    [NUM_CH][DEPTH];
    logic [WIDTH-1:0] mem_d    [NUM_CH][DEPTH];
    logic [PW-1:0]    wr_ptr_q [NUM_CH];
    logic [PW-1:0]    wr_ptr_d [NUM_CH];
    logic [PW-1:0]    rd_ptr_q [NUM_CH];
    logic [PW-1:0]    rd_ptr_d [NUM_CH];
    logic [CW-1:0]    count_q  [NUM_CH];
    logic [CW-1:0]    count_d  [NUM_CH];
    logic [NUM_CH-1:0] overflow_q;
    logic [NUM_CH-1:0] overflow_d;
    logic [NUM_CH-1:0] wrfull_q;
    logic [NUM_CH-1:0] wrfull_d;
    logic [SW-1:0]    sel_q;
    logic [SW-1:0]    sel_d;

    // Handshake qualifiers
    logic              deq_ok_s;
    logic [NUM_CH-1:0] acc_enq_s;
    logic [NUM_CH-1:0] acc_deq_s;
    logic              arb_found_s;

    // Accept logic: writes are gated by the registered full flag of the
    // previous cycle, so a same-cycle pop never makes room for a write.
    always_comb begin
        deq_ok_s = deq && (count_q[sel_q] != CNT_ZERO);
        for (int c = 0; c < NUM_CH; c++) begin
            acc_enq_s[c] = enq[c] && !wrfull_q[c];
            acc_deq_s[c] = deq_ok_s && (sel_q == SW'(c));
        end
    end

    // Next-state for memory, pointers, counters and flags of every channel
    always_comb begin
        mem_d = mem_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (acc_enq_s[c]) begin
                mem_d[c][wr_ptr_q[c]] = data_in[c*WIDTH +: WIDTH];
                wr_ptr_d[c]           = wr_ptr_q[c] + PTR_ONE;
            end else begin
                wr_ptr_d[c] = wr_ptr_q[c];
            end

            if (acc_deq_s[c]) begin
                rd_ptr_d[c] = rd_ptr_q[c] + PTR_ONE;
            end else begin
                rd_ptr_d[c] = rd_ptr_q[c];
            end

            case ({acc_enq_s[c], acc_deq_s[c]})
                2'b10:   count_d[c] = count_q[c] + CNT_ONE;
                2'b01:   count_d[c] = count_q[c] - CNT_ONE;
                default: count_d[c] = count_q[c];
            endcase

            overflow_d[c] = overflow_q[c] | (enq[c] & wrfull_q[c]);
            wrfull_d[c]   = (count_d[c] == CNT_FULL);
        end
    end

    // Round-robin selection: search starts just after the current channel and
    // ends with the current channel itself, using post-update occupancy so a
    // word written into an idle block is presented on the very next cycle.
    always_comb begin
        int cand;
        cand        = 0;
        sel_d       = sel_q;
        arb_found_s = 1'b0;
        if (deq_ok_s || (count_q[sel_q] == CNT_ZERO)) begin
            for (int i = 1; i <= NUM_CH; i++) begin
                cand = int'(sel_q) + i;
                if (cand >= NUM_CH) begin
                    cand = cand - NUM_CH;
                end else begin
                    cand = cand;
                end
                if (!arb_found_s && (count_d[cand] != CNT_ZERO)) begin
                    sel_d       = SW'(cand);
                    arb_found_s = 1'b1;
                end else begin
                    sel_d       = sel_d;
                end
            end
        end else begin
            sel_d = sel_q;
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= {PW{1'b0}};
                rd_ptr_q[c] <= {PW{1'b0}};
                count_q[c]  <= CNT_ZERO;
            end
            overflow_q <= {NUM_CH{1'b0}};
            wrfull_q   <= {NUM_CH{1'b0}};
            sel_q      <= {SW{1'b0}};
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            wrfull_q   <= wrfull_d;
            sel_q      <= sel_d;
        end
    end

    // Word storage; contents are don't-care after reset since counts are zero
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Output mapping
    assign data_out = mem_q[sel_q][rd_ptr_q[sel_q]];
    assign src_ch   = sel_q;
    assign rdempty  = (count_q[sel_q] == CNT_ZERO);
    assign wrfull   = wrfull_q;
    assign overflow = overflow_q;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_count
            assign count[g*CW +: CW] = count_q[g];
        end
    endgenerate

endmodule

// File: doc/req_arb_fifo.md
Name: req_arb_fifo

Overview:
- Multi-channel successor to the single request FIFO feeding the CPU's request interface.
- NUM_CH independent request producers each write into a private FIFO.
- A round-robin arbiter presents one show-ahead read port to the CPU, with the same req_fifo_data / req_fifo_deq / req_fifo_rdempty semantics, plus source channel, per-channel occupancy and sticky overflow flags.

Parameters:
WIDTH, 16, data word width; matches CPU_DATA_WIDTH.
DEPTH, 4, entries per channel FIFO; must be a power of 2, minimum 2.
NUM_CH, 4, number of producer channels; minimum 2.

Ports:
clk  in  1  single clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
data_in  in  NUM_CH*WIDTH  per-channel write data; channel c occupies bits [c*WIDTH +: WIDTH].
enq  in  NUM_CH  per-channel write strobe.
wrfull  out  NUM_CH  per-channel full flag, registered.
data_out  out  WIDTH  head word of the selected channel; valid while rdempty=0.
src_ch  out  $clog2(NUM_CH)  channel index of data_out.
deq  in  1  pop the presented word.
rdempty  out  1  selected channel has no data.
count  out  NUM_CH*($clog2(DEPTH)+1)  per-channel occupancy, registered.
overflow  out  NUM_CH  sticky: enq attempted while that channel was full.

Behaviour:
- Reset, synchronous, while rst=1 at a clock edge:
  - all pointers, counts and overflow bits go to 0; sel (src_ch) goes to 0.
  - Outputs after reset: wrfull=0, rdempty=1, count=0, overflow=0, src_ch=0, data_out=don't-care.
  - Reset during traffic discards all stored words. enq and deq in a reset cycle are ignored.
- Write, per channel c, independent of all other channels:
  - If enq[c]=1 and wrfull[c]=0: store the word at wr_ptr[c]; wr_ptr[c] wraps modulo DEPTH.
  - If enq[c]=1 and wrfull[c]=1: the word is dropped and overflow[c] is set. This holds even if the same cycle dequeues from c, because wrfull is the registered pre-cycle state.
  - overflow[c] is cleared only by reset.
- Read, show-ahead:
  - data_out = mem[sel][rd_ptr[sel]]; rdempty = (count[sel]==0).
  - deq with rdempty=0 pops channel sel: rd_ptr[sel] advances with modulo-DEPTH wrap, and count[sel] decrements.
  - deq with rdempty=1 is ignored, with no state change.
- Counters:
  - count_next[c] = count[c] + accepted_enq[c] - accepted_deq[c].
  - Simultaneous accepted enq and deq on one channel leaves the count unchanged.
  - wrfull[c] = (count[c]==DEPTH).
- Arbitration (sel register):
  - Re-arbitrate when a deq is accepted or count[sel]==0.
  - Search order: sel+1, sel+2, ..., wrapping, ending with sel itself. Pick the first channel with count_next != 0.
  - If none is found, sel holds its value.
  - If there is no deq and count[sel]!=0, sel holds, so the presented word never changes under the consumer.
  - After each accepted pop, service rotates to the next non-empty channel, giving strict round-robin fairness of one word per turn.
- Latency:
  - A word enqueued at edge N on an otherwise empty block is visible (rdempty=0, correct src_ch) from edge N onward, i.e. one cycle after the enq cycle.
  - Single-channel streaming supports one pop per cycle.

Test Plan:
1. Reset, then enq[2]=1 with data 16'hAAAA for one cycle -> next cycle: rdempty=0, src_ch=2, data_out=AAAA, count[2]=1. deq for one cycle -> rdempty=1, count[2]=0.
2. Fill channel 0 with 1,2,3,4, then a fifth enq of 5 -> wrfull[0]=1, overflow[0]=1, word 5 dropped. Drain gives 1,2,3,4 in order, then rdempty=1. overflow[0] stays 1 until rst.
3. Ch0 holds A0,A1; ch1 holds B0,B1; ch3 holds D0. Hold deq=1 continuously -> output order A0,B0,D0,A1,B1 with src_ch 0,1,3,0,1, one word per cycle, then rdempty=1.
4. Channel 1 full (count=4): assert enq[1]=1 and deq=1 in the same cycle -> new word dropped, overflow[1]=1, count=3.
5. Stream 10 words into channel 3, enqueuing and dequeuing every cycle -> the pointer wrap is exercised and all 10 words exit in order, with count[3] stable at 1.
6. With 3 words across channels, assert rst=1 for one cycle while deq=1 -> all counts 0, rdempty=1, src_ch=0, overflow=0, and no word is popped.
